// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and control-field layout for the pipeline stage boundary registers.
package pipe_stage_reg_pkg;

  // Payload/control widths per stage boundary
  localparam int IFID_DATA_W  = 64;   // PC+4, instruction
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 143;  // PC+4, rs, rt, imm, 3 reg indices
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 69;   // ALU result, store data, dest reg
  localparam int EXMEM_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 69;   // mem data, ALU result, dest reg
  localparam int MEMWB_CTRL_W = 2;

  // Control-field bit positions, so every stage packs/unpacks identically
  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEMREAD    = 1;
  localparam int CTRL_MEMWRITE   = 2;
  localparam int CTRL_MEMTOREG   = 3;
  localparam int CTRL_ALUFUN_LSB = 4;
  localparam int CTRL_ALUFUN_W   = 6;
  localparam int CTRL_PCSRC_LSB  = 10;
  localparam int CTRL_PCSRC_W    = 3;

  // Skid-mode occupancy states; encoding equals the entry count
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occState_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + payload + control, with load/clear.
// Control is masked to zero whenever the slot is invalid so a bubble has no side effects.
import pipe_stage_reg_pkg::*;

module pipe_slot #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic [CTRL_W-1:0] ctrlReg;

  // Clear wins over load; payload survives a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      data    <= RST_DATA;
      ctrlReg <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      data    <= inData;
      ctrlReg <= inCtrl;
    end
  end

  assign ctrl = valid ? ctrlReg : '0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, sync flush and
// optional 2-entry skid buffer (SKID=1) that registers in_ready.
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter bit                SKID     = 1'b1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              accept, emit;
  logic              mainLoad, mainClear;
  logic [DATA_W-1:0] mainInData;
  logic [CTRL_W-1:0] mainInCtrl;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RST_DATA(RST_DATA)) uMain (
    .clk    (clk),
    .reset  (reset),
    .load   (mainLoad),
    .clear  (mainClear),
    .inData (mainInData),
    .inCtrl (mainInCtrl),
    .valid  (out_valid),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

  if (SKID) begin : gSkid
    occState_t         state;
    logic              inReadyReg;
    logic              skidLoad, skidClear, skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RST_DATA(RST_DATA)) uSkid (
      .clk    (clk),
      .reset  (reset),
      .load   (skidLoad),
      .clear  (skidClear),
      .inData (in_data),
      .inCtrl (in_ctrl),
      .valid  (skidValid),
      .data   (skidData),
      .ctrl   (skidCtrl)
    );

    // Registered ready is only gated by flush, which must block capture immediately
    assign in_ready  = inReadyReg & ~flush;
    assign occupancy = state;

    // Older skid entry always refills main ahead of any new beat
    assign mainInData = skidValid ? skidData : in_data;
    assign mainInCtrl = skidValid ? skidCtrl : in_ctrl;

    // Slot load/clear strobes derived from occupancy and this edge's transfers
    always_comb begin
      mainLoad  = 1'b0;
      skidLoad  = 1'b0;
      mainClear = flush;
      skidClear = flush;
      if (!flush) begin
        case (state)
          OCC_EMPTY: mainLoad = accept;
          OCC_ONE: begin
            mainLoad  = accept & emit;
            skidLoad  = accept & ~emit;
            mainClear = emit & ~accept;
          end
          OCC_TWO: begin
            mainLoad  = emit;
            skidClear = emit;
          end
          default: ;
        endcase
      end
    end

    // Occupancy FSM; in_ready registered from the next occupancy
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state      <= OCC_EMPTY;
        inReadyReg <= 1'b1;
      end else if (flush) begin
        state      <= OCC_EMPTY;
        inReadyReg <= 1'b1;
      end else begin
        case (state)
          OCC_EMPTY: if (accept) state <= OCC_ONE;
          OCC_ONE: begin
            if (accept & ~emit) begin
              state      <= OCC_TWO;
              inReadyReg <= 1'b0;
            end else if (emit & ~accept) begin
              state      <= OCC_EMPTY;
            end
          end
          OCC_TWO: begin
            if (emit) begin
              state      <= OCC_ONE;
              inReadyReg <= 1'b1;
            end
          end
          default: begin
            state      <= OCC_EMPTY;
            inReadyReg <= 1'b1;
          end
        endcase
      end
    end
  end else begin : gNoSkid
    // Single register: ready whenever the slot frees up this edge
    assign in_ready   = (~out_valid | out_ready) & ~flush;
    assign occupancy  = {1'b0, out_valid};
    assign mainInData = in_data;
    assign mainInCtrl = in_ctrl;
    assign mainLoad   = accept;
    assign mainClear  = flush | (emit & ~accept);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances on shared inputs,
// each predicted by a FIFO-queue reference model.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [DW-1:0] RST_D = 32'hDEAD_0000;

  typedef struct packed { logic [DW-1:0] d; logic [CW-1:0] c; } beat_t;

  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0] occ1, occ0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .RST_DATA(RST_D)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .RST_DATA(RST_D)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0));

  // Reference model: FIFO contents per instance, plus last payload seen at the head
  beat_t q1[$], q0[$], srcQ[$];
  logic [DW-1:0] last1, last0;
  bit acc1;
  int nChecks = 0, nPass = 0;

  function automatic logic [51:0] exp1();
    logic [DW-1:0] d = (q1.size() > 0) ? q1[0].d : last1;
    logic [CW-1:0] c = (q1.size() > 0) ? q1[0].c : '0;
    return {(q1.size() < 2) && !flush, q1.size() > 0, 2'(q1.size()), c, d};
  endfunction

  function automatic logic [51:0] exp0();
    logic [DW-1:0] d = (q0.size() > 0) ? q0[0].d : last0;
    logic [CW-1:0] c = (q0.size() > 0) ? q0[0].c : '0;
    return {(q0.size() == 0 || out_ready) && !flush, q0.size() > 0, 2'(q0.size()), c, d};
  endfunction

  task automatic modelReset();
    q1.delete(); q0.delete(); last1 = RST_D; last0 = RST_D;
  endtask

  // Capacity 2 with registered ready vs capacity 1 with pass-through ready
  task automatic modelEdge();
    bit a0, e1, e0;
    acc1 = in_valid && q1.size() < 2 && !flush;
    e1   = q1.size() > 0 && out_ready;
    a0   = in_valid && (q0.size() == 0 || out_ready) && !flush;
    e0   = q0.size() > 0 && out_ready;
    if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (e1) void'(q1.pop_front());
      if (acc1) q1.push_back(beat_t'{in_data, in_ctrl});
      if (e0) void'(q0.pop_front());
      if (a0) q0.push_back(beat_t'{in_data, in_ctrl});
    end
    if (q1.size() > 0) last1 = q1[0].d;
    if (q0.size() > 0) last0 = q0[0].d;
  endtask

  // Present the source head (held until the SKID=1 instance takes it)
  task automatic drive(input bit ordy, input bit bub, input bit fl);
    in_valid = (srcQ.size() > 0) && !bub;
    if (srcQ.size() > 0) begin in_data = srcQ[0].d; in_ctrl = srcQ[0].c; end
    out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic setIn(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit fl);
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    if (acc1 && srcQ.size() > 0) void'(srcQ.pop_front());
    @(negedge clk);
  endtask

  task automatic drain();
    srcQ.delete();
    setIn(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    modelReset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      setIn(1'b1, DW'($urandom), 16'hFFFF, 1'b1, 1'b0);
      nChecks++;
      if ({ov1, oc1, occ1, od1, ov0, oc0, occ0, od0} !== {1'b0, 16'h0, 2'd0, RST_D, 1'b0, 16'h0, 2'd0, RST_D})
        $display("FAIL reset_hold: got %h %h want 0/0/0/%h", {ov1, oc1, occ1, od1}, {ov0, oc0, occ0, od0}, RST_D);
      else nPass++;
    end
    @(negedge clk);
    reset = 1'b1;
    setIn(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    nChecks++;
    if ({rdy1, rdy0} !== 2'b11) $display("FAIL reset_release_ready: got %b want 11", {rdy1, rdy0});
    else nPass++;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 3; i++) srcQ.push_back(beat_t'{32'h100 + 32'(4 * i), CW'($urandom)});
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(1'b1, 1'b0, 1'b0);
      nChecks++;
      if ({rdy1, ov1, occ1, oc1, od1} !== exp1()) $display("FAIL stream_s1 cyc%0d: got %h want %h", cyc, {rdy1, ov1, occ1, oc1, od1}, exp1());
      else nPass++;
      nChecks++;
      if ({rdy0, ov0, occ0, oc0, od0} !== exp0()) $display("FAIL stream_s0 cyc%0d: got %h want %h", cyc, {rdy0, ov0, occ0, oc0, od0}, exp0());
      else nPass++;
      if (cyc >= 1 && cyc <= 3) begin
        nChecks++;
        if ({ov1, od1, ov0, od0} !== {1'b1, 32'h100 + 32'(4 * (cyc - 1)), 1'b1, 32'h100 + 32'(4 * (cyc - 1))})
          $display("FAIL stream_value cyc%0d: got %h/%h want %h", cyc, od1, od0, 32'h100 + 32'(4 * (cyc - 1)));
        else nPass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_stall();
    beat_t got[$];
    logic [95:0] gv;
    srcQ.push_back(beat_t'{32'hA, 16'h0011});
    srcQ.push_back(beat_t'{32'hB, 16'h0022});
    srcQ.push_back(beat_t'{32'hC, 16'h0033});
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive(cyc == 0, 1'b0, 1'b0);
      nChecks++;
      if ({rdy1, ov1, occ1, oc1, od1} !== exp1()) $display("FAIL stall_s1 cyc%0d: got %h want %h", cyc, {rdy1, ov1, occ1, oc1, od1}, exp1());
      else nPass++;
      nChecks++;
      if ({rdy0, ov0, occ0, oc0, od0} !== exp0()) $display("FAIL stall_s0 cyc%0d: got %h want %h", cyc, {rdy0, ov0, occ0, oc0, od0}, exp0());
      else nPass++;
      if (cyc == 2) begin
        nChecks++;
        if ({ov1, occ1, rdy1, od1} !== {1'b1, 2'd2, 1'b0, 32'hA})
          $display("FAIL stall_full: got v%b occ%0d rdy%b d%h want v1 occ2 rdy0 dA", ov1, occ1, rdy1, od1);
        else nPass++;
      end
      tick();
    end
    for (int cyc = 0; cyc < 12 && (srcQ.size() > 0 || q1.size() > 0); cyc++) begin
      drive(1'b1, 1'b0, 1'b0);
      nChecks++;
      if ({rdy1, ov1, occ1, oc1, od1} !== exp1()) $display("FAIL stall_drain_s1 cyc%0d: got %h want %h", cyc, {rdy1, ov1, occ1, oc1, od1}, exp1());
      else nPass++;
      if (ov1) got.push_back(beat_t'{od1, oc1});
      tick();
    end
    gv = (got.size() == 3) ? {got[0].d, got[1].d, got[2].d} : '1;
    nChecks++;
    if (gv !== {32'hA, 32'hB, 32'hC}) $display("FAIL stall_order: got %h (n=%0d) want a/b/c", gv, got.size());
    else nPass++;
    drain();
  endtask

  task automatic test_flush();
    srcQ.push_back(beat_t'{32'h1111, 16'hFFFF});
    srcQ.push_back(beat_t'{32'h2222, 16'hFFFF});
    srcQ.push_back(beat_t'{32'h3333, 16'hFFFF});
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0);
    nChecks++;
    if ({occ1, oc1} !== {2'd2, 16'hFFFF}) $display("FAIL flush_prefill: got occ%0d ctrl%h want occ2 ctrl ffff", occ1, oc1);
    else nPass++;
    drive(1'b0, 1'b0, 1'b1);
    nChecks++;
    if ({rdy1, rdy0} !== 2'b00) $display("FAIL flush_ready: got %b want 00", {rdy1, rdy0});
    else nPass++;
    nChecks++;
    if ({rdy1, ov1, occ1, oc1, od1} !== exp1()) $display("FAIL flush_s1: got %h want %h", {rdy1, ov1, occ1, oc1, od1}, exp1());
    else nPass++;
    tick();
    srcQ.delete();
    drive(1'b0, 1'b0, 1'b0);
    nChecks++;
    if ({ov1, oc1, occ1, ov0, oc0, occ0} !== '0)
      $display("FAIL flush_clear: got %h %h want 0", {ov1, oc1, occ1}, {ov0, oc0, occ0});
    else nPass++;
    nChecks++;
    if ({od1, od0} !== {32'h1111, 32'h1111}) $display("FAIL flush_payload_kept: got %h/%h want 1111", od1, od0);
    else nPass++;
    drain();
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 4; i++) srcQ.push_back(beat_t'{DW'($urandom), CW'($urandom) | 16'h1});
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive(1'b1, cyc == 2 || cyc == 3, 1'b0);
      nChecks++;
      if ({rdy1, ov1, occ1, oc1, od1} !== exp1()) $display("FAIL bubble_s1 cyc%0d: got %h want %h", cyc, {rdy1, ov1, occ1, oc1, od1}, exp1());
      else nPass++;
      nChecks++;
      if ({rdy0, ov0, occ0, oc0, od0} !== exp0()) $display("FAIL bubble_s0 cyc%0d: got %h want %h", cyc, {rdy0, ov0, occ0, oc0, od0}, exp0());
      else nPass++;
      if (cyc == 3 || cyc == 4) begin
        nChecks++;
        if ({ov1, oc1, ov0, oc0} !== '0) $display("FAIL bubble_ctrl cyc%0d: got %h/%h want 0", cyc, oc1, oc0);
        else nPass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_skid0();
    setIn(1'b1, 32'h5A5A, 16'h00F0, 1'b1, 1'b0); tick();
    setIn(1'b1, 32'hC3C3, 16'h0F00, 1'b0, 1'b0);
    nChecks++;
    if ({ov0, od0, rdy0} !== {1'b1, 32'h5A5A, 1'b0}) $display("FAIL skid0_stall: got v%b d%h rdy%b want v1 d5a5a rdy0", ov0, od0, rdy0);
    else nPass++;
    tick();
    setIn(1'b1, 32'hC3C3, 16'h0F00, 1'b1, 1'b0);
    nChecks++;
    if ({ov0, od0, rdy0} !== {1'b1, 32'h5A5A, 1'b1}) $display("FAIL skid0_release: got v%b d%h rdy%b want v1 d5a5a rdy1", ov0, od0, rdy0);
    else nPass++;
    tick();
    setIn(1'b0, '0, '0, 1'b1, 1'b0);
    nChecks++;
    if ({ov0, od0, oc0, occ0} !== {1'b1, 32'hC3C3, 16'h0F00, 2'd1}) $display("FAIL skid0_swap: got v%b d%h c%h want v1 dc3c3 c0f00", ov0, od0, oc0);
    else nPass++;
    drain();
  endtask

  task automatic test_reset_mid();
    setIn(1'b1, 32'h7777, 16'hABCD, 1'b0, 1'b0); tick();
    setIn(1'b1, 32'h8888, 16'hABCD, 1'b0, 1'b0); tick();
    setIn(1'b1, 32'h9999, 16'hABCD, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    nChecks++;
    if ({ov1, oc1, occ1, od1, ov0, oc0, occ0, od0} !== {1'b0, 16'h0, 2'd0, RST_D, 1'b0, 16'h0, 2'd0, RST_D})
      $display("FAIL reset_async: got %h %h want cleared", {ov1, oc1, occ1, od1}, {ov0, oc0, occ0, od0});
    else nPass++;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    drain();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      setIn($urandom_range(0, 9) < 7, DW'($urandom), CW'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      nChecks++;
      if ({rdy1, ov1, occ1, oc1, od1} !== exp1()) $display("FAIL rand_s1 cyc%0d: got %h want %h", cyc, {rdy1, ov1, occ1, oc1, od1}, exp1());
      else nPass++;
      nChecks++;
      if ({rdy0, ov0, occ0, oc0, od0} !== exp0()) $display("FAIL rand_s0 cyc%0d: got %h want %h", cyc, {rdy0, ov0, occ0, oc0, od0}, exp0());
      else nPass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_skid0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
